// File: rtl/instruction_loader.sv
// instruction_loader: streams received bytes into the byte-wide instruction
// memory after a start command, assembling 32-bit words MSB first, and ends
// the load on HALT (done) or when memory fills without HALT (error).
module instruction_loader #(
    parameter int unsigned MEMORY_WIDTH     = 8,
    parameter int unsigned MEMORY_DEPTH     = 64,
    parameter int unsigned NB_ADDR          = 32,
    parameter int unsigned NB_INSTRUCTION   = 32,
    parameter logic [NB_INSTRUCTION-1:0] HALT_INSTRUCTION = 32'hFFFFFFFF,
    parameter int unsigned NB_COUNT         = 8
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [MEMORY_WIDTH-1:0] i_rx_data,
    input  logic                    i_rx_valid,
    output logic                    o_rx_ready,
    output logic                    o_wr_enable,
    output logic [NB_ADDR-1:0]      o_wr_addr,
    output logic [MEMORY_WIDTH-1:0] o_wr_data,
    output logic                    o_loading,
    output logic                    o_done,
    output logic                    o_error,
    output logic [NB_COUNT-1:0]     o_instr_count
);

    localparam int unsigned BYTES_PER_INSTR = NB_INSTRUCTION / MEMORY_WIDTH;
    localparam int unsigned NB_BYTE_IDX     = $clog2(BYTES_PER_INSTR);
    // Only the older bytes of a word need storing; the newest comes straight off the bus.
    localparam int unsigned NB_SHIFT        = NB_INSTRUCTION - MEMORY_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t                    state_q;
    state_t                    state_next;
    logic [NB_ADDR-1:0]        addr_q;
    logic [NB_ADDR-1:0]        addr_next;
    logic [NB_BYTE_IDX-1:0]    byte_idx_q;
    logic [NB_BYTE_IDX-1:0]    byte_idx_next;
    logic [NB_SHIFT-1:0]       word_q;
    logic [NB_SHIFT-1:0]       word_next;
    logic [NB_INSTRUCTION-1:0] word_full;
    logic [NB_COUNT-1:0]       count_next;
    logic                      wr_enable_next;
    logic [NB_ADDR-1:0]        wr_addr_next;
    logic [MEMORY_WIDTH-1:0]   wr_data_next;
    logic                      rx_ready_next;
    logic                      loading_next;
    logic                      done_next;
    logic                      error_next;
    logic                      accept;

    // A byte is consumed only while the loader advertises ready.
    assign accept = i_rx_valid && o_rx_ready;

    // State, datapath and registered outputs; reset discards any pending write.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            byte_idx_q    <= '0;
            word_q        <= '0;
            o_instr_count <= '0;
            o_wr_enable   <= 1'b0;
            o_wr_addr     <= '0;
            o_wr_data     <= '0;
            o_rx_ready    <= 1'b0;
            o_loading     <= 1'b0;
            o_done        <= 1'b0;
            o_error       <= 1'b0;
        end else begin
            state_q       <= state_next;
            addr_q        <= addr_next;
            byte_idx_q    <= byte_idx_next;
            word_q        <= word_next;
            o_instr_count <= count_next;
            o_wr_enable   <= wr_enable_next;
            o_wr_addr     <= wr_addr_next;
            o_wr_data     <= wr_data_next;
            o_rx_ready    <= rx_ready_next;
            o_loading     <= loading_next;
            o_done        <= done_next;
            o_error       <= error_next;
        end
    end

    // Next-state, byte assembly and termination decision.
    always_comb begin
        state_next     = state_q;
        addr_next      = addr_q;
        byte_idx_next  = byte_idx_q;
        word_next      = word_q;
        count_next     = o_instr_count;
        wr_enable_next = 1'b0;
        wr_addr_next   = o_wr_addr;
        wr_data_next   = o_wr_data;
        word_full      = {word_q, i_rx_data};

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    wr_enable_next = 1'b1;
                    wr_addr_next   = addr_q;
                    wr_data_next   = i_rx_data;
                    addr_next      = addr_q + NB_ADDR'(1);
                    word_next      = word_full[NB_SHIFT-1:0];
                    byte_idx_next  = byte_idx_q + NB_BYTE_IDX'(1);
                    if (byte_idx_q == NB_BYTE_IDX'(BYTES_PER_INSTR - 1)) begin
                        if (o_instr_count != '1) begin
                            count_next = o_instr_count + NB_COUNT'(1);
                        end
                        if (word_full == HALT_INSTRUCTION) begin
                            state_next = ST_DONE;
                        end else if (addr_q == NB_ADDR'(MEMORY_DEPTH - 1)) begin
                            state_next = ST_ERROR;
                        end
                    end
                end
            end
            default: begin
                // IDLE, DONE and ERROR all restart the same way; memory is not cleared.
                if (i_start) begin
                    state_next    = ST_LOAD;
                    addr_next     = '0;
                    byte_idx_next = '0;
                    word_next     = '0;
                    count_next    = '0;
                end
            end
        endcase

        rx_ready_next = (state_next == ST_LOAD);
        loading_next  = (state_next == ST_LOAD);
        done_next     = (state_next == ST_DONE);
        error_next    = (state_next == ST_ERROR);
    end

endmodule
